latch_write_seq: RTL and testbench

Synchronous driver for a bank of level-sensitive D latches: accepts a data word over a valid/ready handshake and produces the `D`/`enable` write sequence with programmable setup, pulse and hold phases. It also reads back the latch `Q` to confirm that the write landed. It sits between synchronous logic and latch-based storage, and is the initiating end of the latch `D`/`enable`/`Q` interface.

---
 rtl/latch_write_seq.sv | 142 ++++++++++++++
 tb/tb_latch_write_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/latch_write_seq.sv
// Drives a latch bank with a D/enable write sequence (setup, pulse, hold phases)
// and checks the latch Q readback once the write has completed.
module latch_write_seq #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] D,
    output logic             enable,
    input  logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [7:0]       err_count
);

    localparam int unsigned SP_MAX  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned MAX_CYC = (SP_MAX > HOLD_CYC) ? SP_MAX : HOLD_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             en_q, en_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mis_q, mis_d;
    logic [7:0]       err_q, err_d;
    logic             rb_bad;

    assign rb_bad = (Q != d_q);

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            en_q    <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            en_q    <= en_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; D only moves on accept, enable only on phase changes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        en_d    = en_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mis_d   = mis_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && rdy_q) begin
                    d_d     = in_data;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    rdy_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    en_d    = 1'b1;
                    cnt_d   = CNT_W'(PULSE_CYC - 1);
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    en_d    = 1'b0;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    mis_d   = rb_bad;
                    if (rb_bad && (err_q != 8'hFF)) begin
                        err_d = err_q + 8'd1;
                    end
                    rdy_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                en_d    = 1'b0;
                rdy_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign in_ready  = rdy_q;
    assign D         = d_q;
    assign enable    = en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mismatch  = mis_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_latch_write_seq.sv
// Scoreboard bench for latch_write_seq: default instance against a behavioural
// latch (optionally stuck at zero) plus a second instance with S=3, P=1, H=2.
module tb_latch_write_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] in_data, d, q, q_lat, err_count;
    logic       in_valid, in_ready, enable, busy, done, mismatch, stuck;

    logic [7:0] in_data2, d2, q2_lat, err2;
    logic       in_valid2, in_ready2, en2, busy2, done2, mis2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int model_err;

    typedef struct {
        logic [7:0] data;
        logic       mis;
        logic [7:0] err;
        int         due;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    latch_write_seq dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .D(d), .enable(enable), .Q(q), .busy(busy),
        .done(done), .mismatch(mismatch), .err_count(err_count)
    );

    latch_write_seq #(.WIDTH(8), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .D(d2), .enable(en2), .Q(q2_lat), .busy(busy2),
        .done(done2), .mismatch(mis2), .err_count(err2)
    );

    // Behavioural D latches on the bank side
    always_latch if (enable) q_lat <= d;
    always_latch if (en2) q2_lat <= d2;
    assign q = stuck ? 8'h00 : q_lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents a word (leaves in_valid high) and records the expected outcome on accept
    task automatic send(input logic [7:0] data);
        bit   acc;
        exp_t e;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = data;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        if (!acc) begin
            check("send_timeout", in_ready, 1);
        end else begin
            e.data = data;
            e.mis  = stuck && (data != 8'h00);
            if (e.mis && model_err != 255) model_err++;
            e.err  = 8'(model_err);
            e.due  = cyc + 4;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        check(tag, sb.size(), 0);
    endtask

    // Output monitor: pops the scoreboard on done, checks D/enable edge separation and enable gaps
    logic       mon_rst;
    logic [7:0] prev_d;
    logic       prev_en;
    int         low_run = 0;
    always @(posedge clk) begin
        mon_rst = rst;
        #1;
        if (!mon_rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", done, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("sb_data", d, mon_e.data);
                    check("sb_mismatch", mismatch, mon_e.mis);
                    check("sb_err_count", err_count, mon_e.err);
                    check("sb_latency", cyc, mon_e.due);
                end
            end
            check("d_en_same_edge", (d != prev_d) && (enable != prev_en), 0);
            if (enable && !prev_en) check("en_low_gap", low_run >= 1, 1);
        end
        low_run = enable ? 0 : low_run + 1;
        prev_d  = d;
        prev_en = enable;
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; stuck = 1'b0;
        in_valid2 = 1'b0; in_data2 = 8'h00; model_err = 0;
        tick(); tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_d", d, 8'h00);
        check("rst_enable", enable, 0);
        check("rst_done", done, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_err_count", err_count, 0);
        check("rst_in_ready2", in_ready2, 1);
        check("rst_enable2", en2, 0);
        rst = 1'b0;
        tick();

        // Single write with defaults
        send(8'hA5);
        in_valid = 1'b0;
        check("wr_d", d, 8'hA5);
        check("wr_busy", busy, 1);
        check("wr_in_ready", in_ready, 0);
        check("wr_enable_t0", enable, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("wr_enable", enable, (k == 1 || k == 2));
            check("wr_done", done, (k == 4));
            check("wr_busy_k", busy, (k != 4));
        end
        check("wr_in_ready_done", in_ready, 1);
        check("wr_mismatch", mismatch, 0);
        tick();
        check("wr_done_one_cycle", done, 0);

        // Second instance: S=3, P=1, H=2
        in_valid2 = 1'b1; in_data2 = 8'hC3;
        tick();
        in_valid2 = 1'b0; in_data2 = 8'hFF;
        check("p_d", d2, 8'hC3);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("p_enable", en2, (k == 3));
            check("p_done", done2, (k == 6));
        end
        check("p_mismatch", mis2, 0);
        check("p_err", err2, 0);

        // Reset while enable is high aborts the sequence
        send(8'h5A);
        in_valid = 1'b0;
        tick();
        check("rmid_enable_before", enable, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("rmid_enable", enable, 0);
        check("rmid_in_ready", in_ready, 1);
        check("rmid_busy", busy, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rmid_no_done", done, 0);
        end
        check("rmid_err", err_count, 8'(model_err));

        // Readback stuck at zero
        stuck = 1'b1;
        send(8'h3C);
        in_valid = 1'b0;
        drain("stuck_drain");
        check("stuck_mismatch", mismatch, 1);
        check("stuck_err", err_count, 1);
        send(8'h00);
        in_valid = 1'b0;
        drain("stuck_zero_drain");
        check("stuck_zero_mismatch", mismatch, 0);
        check("stuck_zero_err", err_count, 1);

        // Back-to-back with in_valid held high
        stuck = 1'b0;
        send(8'h11);
        send(8'h22);
        send(8'h33);
        in_valid = 1'b0;
        drain("b2b_drain");
        check("b2b_last_d", d, 8'h33);

        // Saturation of err_count
        stuck = 1'b1;
        for (int i = 0; i < 260; i++) send(8'(i) | 8'h80);
        in_valid = 1'b0;
        drain("sat_drain");
        check("sat_err", err_count, 8'd255);
        check("sat_mismatch", mismatch, 1);
        stuck = 1'b0;

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
